// File: rtl/pbs_pkg.sv
// rtl/pbs_pkg.sv - shared states, winner codes and turn/target encodings for the PBS battle controller
package pbs_pkg;

    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_INIT    = 4'd1,
        ST_P_SEL   = 4'd2,
        ST_P_ACT   = 4'd3,
        ST_P_CALC  = 4'd4,
        ST_P_APPLY = 4'd5,
        ST_P_CHK   = 4'd6,
        ST_A_ACT   = 4'd7,
        ST_A_CALC  = 4'd8,
        ST_A_APPLY = 4'd9,
        ST_A_CHK   = 4'd10,
        ST_OVER    = 4'd11
    } pbs_state_t;

    localparam logic [1:0] WINNER_NONE   = 2'b00;
    localparam logic [1:0] WINNER_PLAYER = 2'b01;
    localparam logic [1:0] WINNER_AI     = 2'b10;
    localparam logic [1:0] WINNER_DRAW   = 2'b11;

    localparam logic TGT_PLAYER  = 1'b0;
    localparam logic TGT_AI      = 1'b1;
    localparam logic ACTR_PLAYER = 1'b0;
    localparam logic ACTR_AI     = 1'b1;

    localparam logic [3:0] HP_INIT = 4'd9;

endpackage

// File: rtl/pbs_ctrl_if.sv
// rtl/pbs_ctrl_if.sv - player move valid/ready handshake between button front end and controller
interface pbs_ctrl_if;
    logic       move_valid;
    logic [1:0] move_in;
    logic       move_ready;

    modport master (output move_valid, output move_in, input move_ready);
    modport slave  (input move_valid, input move_in, output move_ready);
endinterface

// File: rtl/pbs_wait_cnt.sv
// rtl/pbs_wait_cnt.sv - loadable down-counter; done is high while the count sits at zero
module pbs_wait_cnt #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         done
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done = (cnt_q == '0);

endmodule

// File: rtl/pbs_ctrl.sv
// rtl/pbs_ctrl.sv - PBS battle sequencer: player/AI turns, calc/apply phases, winner decision
// Optional draw after MAX_TURNS rounds when PBS_TURN_LIMIT_EN is defined.
module pbs_ctrl
    import pbs_pkg::*;
#(
    parameter int WAIT_CYC  = 2,
    parameter int MAX_TURNS = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    pbs_ctrl_if.slave   mv,
    input  logic [3:0]  p_hp,
    input  logic [3:0]  AI_hp,
    output logic        dp_rst_n,
    output logic        target,
    output logic [1:0]  p_move,
    output logic        actr,
    output logic        calc_dmg,
    output logic        app_dmg,
    output logic        game_over,
    output logic [1:0]  winner
);

    localparam int CNT_W = $clog2(WAIT_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYC - 1);

    pbs_state_t state_q, state_d;
    logic [1:0] winner_q, winner_d;
    logic [1:0] p_move_q, p_move_d;
    logic       cnt_load;
    logic       cnt_done;

`ifdef PBS_TURN_LIMIT_EN
    localparam logic [3:0] TURN_LIMIT = 4'(MAX_TURNS);
    logic [3:0] turn_q, turn_d;
`else
    wire unused_max_turns;
    assign unused_max_turns = ^MAX_TURNS;
`endif

    // One counter serves every CALC/APPLY phase; it is reloaded on each phase entry.
    pbs_wait_cnt #(.W(CNT_W)) u_wait (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (CNT_LOAD),
        .done     (cnt_done)
    );

    always_comb begin
        state_d       = state_q;
        winner_d      = winner_q;
        p_move_d      = p_move_q;
        cnt_load      = 1'b0;
        mv.move_ready = 1'b0;
        dp_rst_n      = 1'b1;
        actr          = ACTR_PLAYER;
        target        = TGT_PLAYER;
        calc_dmg      = 1'b0;
        app_dmg       = 1'b0;
        game_over     = 1'b0;
`ifdef PBS_TURN_LIMIT_EN
        turn_d        = turn_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_INIT;
            end
            ST_INIT: begin
                dp_rst_n = 1'b0;
                winner_d = WINNER_NONE;
`ifdef PBS_TURN_LIMIT_EN
                turn_d   = '0;
`endif
                state_d  = ST_P_SEL;
            end
            ST_P_SEL: begin
                mv.move_ready = 1'b1;
                if (mv.move_valid) begin
                    p_move_d = mv.move_in;
                    state_d  = ST_P_ACT;
                end
            end
            ST_P_ACT, ST_P_CALC, ST_P_APPLY, ST_P_CHK: begin
                actr   = ACTR_PLAYER;
                target = TGT_AI;
                if (state_q == ST_P_ACT) begin
                    cnt_load = 1'b1;
                    state_d  = ST_P_CALC;
                end else if (state_q == ST_P_CALC) begin
                    calc_dmg = 1'b1;
                    if (cnt_done) begin
                        cnt_load = 1'b1;
                        state_d  = ST_P_APPLY;
                    end
                end else if (state_q == ST_P_APPLY) begin
                    app_dmg = 1'b1;
                    if (cnt_done) state_d = ST_P_CHK;
                end else if (AI_hp == 4'd0) begin
                    winner_d = WINNER_PLAYER;
                    state_d  = ST_OVER;
                end else begin
                    state_d = ST_A_ACT;
                end
            end
            ST_A_ACT, ST_A_CALC, ST_A_APPLY, ST_A_CHK: begin
                actr   = ACTR_AI;
                target = TGT_PLAYER;
                if (state_q == ST_A_ACT) begin
                    cnt_load = 1'b1;
                    state_d  = ST_A_CALC;
                end else if (state_q == ST_A_CALC) begin
                    calc_dmg = 1'b1;
                    if (cnt_done) begin
                        cnt_load = 1'b1;
                        state_d  = ST_A_APPLY;
                    end
                end else if (state_q == ST_A_APPLY) begin
                    app_dmg = 1'b1;
                    if (cnt_done) state_d = ST_A_CHK;
                end else if (p_hp == 4'd0) begin
                    winner_d = WINNER_AI;
                    state_d  = ST_OVER;
                end else begin
`ifdef PBS_TURN_LIMIT_EN
                    if (turn_q + 4'd1 == TURN_LIMIT) begin
                        winner_d = WINNER_DRAW;
                        state_d  = ST_OVER;
                    end else begin
                        turn_d  = turn_q + 4'd1;
                        state_d = ST_P_SEL;
                    end
`else
                    state_d = ST_P_SEL;
`endif
                end
            end
            ST_OVER: begin
                game_over = 1'b1;
                if (start) begin
                    winner_d = WINNER_NONE;
                    state_d  = ST_INIT;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            winner_q <= WINNER_NONE;
            p_move_q <= 2'b00;
`ifdef PBS_TURN_LIMIT_EN
            turn_q   <= '0;
`endif
        end else begin
            state_q  <= state_d;
            winner_q <= winner_d;
            p_move_q <= p_move_d;
`ifdef PBS_TURN_LIMIT_EN
            turn_q   <= turn_d;
`endif
        end
    end

    assign winner = winner_q;
    assign p_move = p_move_q;

endmodule

// File: tb/tb_pbs_ctrl.sv
// tb/tb_pbs_ctrl.sv - directed bench for pbs_ctrl (WAIT_CYC=2; draw check when PBS_TURN_LIMIT_EN is defined)
module tb_pbs_ctrl;
    import pbs_pkg::*;

    logic       clk;
    logic       rst;
    logic       start;
    logic [3:0] p_hp;
    logic [3:0] ai_hp;
    logic       dp_rst_n;
    logic       target;
    logic [1:0] p_move;
    logic       actr;
    logic       calc_dmg;
    logic       app_dmg;
    logic       game_over;
    logic [1:0] winner;

    int checks   = 0;
    int failures = 0;

    pbs_ctrl_if mv ();

    pbs_ctrl #(.WAIT_CYC(2), .MAX_TURNS(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .mv        (mv),
        .p_hp      (p_hp),
        .AI_hp     (ai_hp),
        .dp_rst_n  (dp_rst_n),
        .target    (target),
        .p_move    (p_move),
        .actr      (actr),
        .calc_dmg  (calc_dmg),
        .app_dmg   (app_dmg),
        .game_over (game_over),
        .winner    (winner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Fields: dp_rst_n, move_ready, actr, target, calc_dmg, app_dmg, game_over, winner[1:0], p_move[1:0]
    function automatic logic [10:0] mk(input logic dr, rdy, ac, tg, ca, ap, go,
                                       input logic [1:0] wn, pm);
        return {dr, rdy, ac, tg, ca, ap, go, wn, pm};
    endfunction

    task automatic chk(input string tag, input logic [10:0] exp);
        logic [10:0] obs;
        obs = {dp_rst_n, mv.move_ready, actr, target, calc_dmg, app_dmg, game_over, winner, p_move};
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    initial begin
        rst           = 1'b0;
        start         = 1'b0;
        mv.move_valid = 1'b0;
        mv.move_in    = 2'b00;
        p_hp          = HP_INIT;
        ai_hp         = HP_INIT;
        step();
        step();
        chk("reset_state", mk(1,0,0,0,0,0,0,2'b00,2'b00));

        // Start from IDLE: INIT pulses dp_rst_n, then P_SEL on the third cycle
        rst = 1'b1;
        step();
        chk("idle_after_reset", mk(1,0,0,0,0,0,0,2'b00,2'b00));
        start = 1'b1;
        step();
        chk("init_dp_rst_low", mk(0,0,0,0,0,0,0,2'b00,2'b00));
        start = 1'b0;
        step();
        chk("psel_ready", mk(1,1,0,0,0,0,0,2'b00,2'b00));
        step();
        chk("psel_waits", mk(1,1,0,0,0,0,0,2'b00,2'b00));

        // Player turn with move 10
        mv.move_valid = 1'b1;
        mv.move_in    = 2'b10;
        step();
        mv.move_valid = 1'b0;
        chk("p_act", mk(1,0,0,1,0,0,0,2'b00,2'b10));
        step();
        chk("p_calc1", mk(1,0,0,1,1,0,0,2'b00,2'b10));
        step();
        chk("p_calc2", mk(1,0,0,1,1,0,0,2'b00,2'b10));
        step();
        chk("p_apply1", mk(1,0,0,1,0,1,0,2'b00,2'b10));
        step();
        chk("p_apply2", mk(1,0,0,1,0,1,0,2'b00,2'b10));
        step();
        chk("p_chk", mk(1,0,0,1,0,0,0,2'b00,2'b10));
        step();
        chk("a_act", mk(1,0,1,0,0,0,0,2'b00,2'b10));
        step();
        chk("a_calc1", mk(1,0,1,0,1,0,0,2'b00,2'b10));
        // move_valid during AI turn must be ignored
        mv.move_valid = 1'b1;
        mv.move_in    = 2'b01;
        step();
        chk("a_calc2_ignore_move", mk(1,0,1,0,1,0,0,2'b00,2'b10));
        mv.move_valid = 1'b0;
        step();
        chk("a_apply1", mk(1,0,1,0,0,1,0,2'b00,2'b10));
        step();
        chk("a_apply2", mk(1,0,1,0,0,1,0,2'b00,2'b10));
        step();
        chk("a_chk", mk(1,0,1,0,0,0,0,2'b00,2'b10));
        step();
        chk("round_back_psel", mk(1,1,0,0,0,0,0,2'b00,2'b10));

        // AI HP reaches 0 during player apply: player wins, AI never acts
        mv.move_valid = 1'b1;
        mv.move_in    = 2'b01;
        step();
        mv.move_valid = 1'b0;
        chk("p_act_r2", mk(1,0,0,1,0,0,0,2'b00,2'b01));
        step();
        step();
        step();
        ai_hp = 4'd0;
        step();
        chk("p_apply2_r2", mk(1,0,0,1,0,1,0,2'b00,2'b01));
        step();
        chk("p_chk_r2", mk(1,0,0,1,0,0,0,2'b00,2'b01));
        step();
        chk("over_player_wins", mk(1,0,0,0,0,0,1,2'b01,2'b01));
        step();
        chk("over_held", mk(1,0,0,0,0,0,1,2'b01,2'b01));
        ai_hp = HP_INIT;

        // Restart from OVER, then player HP reaches 0 during AI apply
        start = 1'b1;
        step();
        start = 1'b0;
        chk("restart_init", mk(0,0,0,0,0,0,0,2'b00,2'b01));
        step();
        chk("restart_psel", mk(1,1,0,0,0,0,0,2'b00,2'b01));
        mv.move_valid = 1'b1;
        mv.move_in    = 2'b11;
        step();
        mv.move_valid = 1'b0;
        repeat (6) step();
        chk("a_act_r3", mk(1,0,1,0,0,0,0,2'b00,2'b11));
        step();
        step();
        step();
        p_hp = 4'd0;
        step();
        chk("a_apply2_r3", mk(1,0,1,0,0,1,0,2'b00,2'b11));
        step();
        chk("a_chk_r3", mk(1,0,1,0,0,0,0,2'b00,2'b11));
        step();
        chk("over_ai_wins", mk(1,0,0,0,0,0,1,2'b10,2'b11));
        start = 1'b1;
        step();
        start = 1'b0;
        p_hp  = HP_INIT;
        chk("restart2_init_clears", mk(0,0,0,0,0,0,0,2'b00,2'b11));
        step();
        chk("restart2_psel", mk(1,1,0,0,0,0,0,2'b00,2'b11));

        // start outside IDLE/OVER is ignored
        start = 1'b1;
        step();
        start = 1'b0;
        chk("start_ignored_psel", mk(1,1,0,0,0,0,0,2'b00,2'b11));

        // Reset in the middle of P_CALC
        mv.move_valid = 1'b1;
        mv.move_in    = 2'b01;
        step();
        mv.move_valid = 1'b0;
        step();
        chk("p_calc_before_rst", mk(1,0,0,1,1,0,0,2'b00,2'b01));
        rst = 1'b0;
        step();
        chk("rst_mid_calc_idle", mk(1,0,0,0,0,0,0,2'b00,2'b00));
        rst = 1'b1;
        step();
        chk("idle_after_mid_rst", mk(1,0,0,0,0,0,0,2'b00,2'b00));

`ifdef PBS_TURN_LIMIT_EN
        // Turn limit 3: draw after third AI check with no HP reaching 0
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        chk("tl_psel", mk(1,1,0,0,0,0,0,2'b00,2'b00));
        for (int r = 0; r < 3; r++) begin
            mv.move_valid = 1'b1;
            mv.move_in    = 2'b10;
            step();
            mv.move_valid = 1'b0;
            repeat (12) step();
            if (r < 2) begin
                chk("tl_round_psel", mk(1,1,0,0,0,0,0,2'b00,2'b10));
            end else begin
                chk("tl_draw", mk(1,0,0,0,0,0,1,2'b11,2'b10));
            end
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
